// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and off-chip memory.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int unsigned INDEX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W   = 32 - 5 - INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FETCH,
    S_REFILL
  } state_e;

  state_e state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_data_q, mem_data_d;

  logic [INDEX_W-1:0]   idx_c;
  logic [TAG_W-1:0]     tag_c;
  logic [7:0]           word_base_c;
  logic [LINE_BITS-1:0] line_c;
  logic                 hit_c;
  logic                 miss_c;
  logic                 victim_dirty_c;
  logic                 wr_hit_c;
  logic                 fill_c;
  logic                 wb_done_c;
  logic                 unused_addr_c;

  // Address decomposition; the two byte-offset bits are unused for word accesses.
  assign idx_c          = cpu_addr_i[5+INDEX_W-1:5];
  assign tag_c          = cpu_addr_i[31:5+INDEX_W];
  assign word_base_c    = {cpu_addr_i[4:2], 5'b00000};
  assign line_c         = data_q[idx_c];
  assign unused_addr_c  = &{1'b0, cpu_addr_i[1:0]};

  assign hit_c          = cpu_req_i & valid_q[idx_c] & (tag_q[idx_c] == tag_c);
  assign miss_c         = cpu_req_i & ~hit_c;
  assign victim_dirty_c = valid_q[idx_c] & dirty_q[idx_c];

  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;

  // State and memory-side output register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Next state; memory outputs are only reloaded on state entry.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    cpu_stall_o = 1'b1;
    cpu_data_o  = '0;
    wr_hit_c    = 1'b0;
    fill_c      = 1'b0;
    wb_done_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cpu_stall_o = miss_c;
        if (hit_c) begin
          if (cpu_we_i) begin
            wr_hit_c = 1'b1;
          end else begin
            cpu_data_o = line_c[word_base_c +: 32];
          end
        end
        if (miss_c) begin
          mem_req_d = 1'b1;
          if (victim_dirty_c) begin
            state_d    = S_WB;
            mem_we_d   = 1'b1;
            mem_addr_d = {tag_q[idx_c], idx_c, 5'b00000};
            mem_data_d = line_c;
          end else begin
            state_d    = S_FETCH;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag_c, idx_c, 5'b00000};
          end
        end
      end
      S_WB: begin
        if (mem_ack_i) begin
          wb_done_c  = 1'b1;
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {tag_c, idx_c, 5'b00000};
        end
      end
      S_FETCH: begin
        if (mem_ack_i) begin
          fill_c    = 1'b1;
          state_d   = S_REFILL;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      S_REFILL: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Line status bits; cleared by reset so a reset mid-miss leaves nothing valid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_c) begin
        valid_q[idx_c] <= 1'b1;
        dirty_q[idx_c] <= 1'b0;
      end else if (wb_done_c) begin
        dirty_q[idx_c] <= 1'b0;
      end else if (wr_hit_c) begin
        dirty_q[idx_c] <= 1'b1;
      end
    end
  end

  // Tag and data storage need no reset; valid_q qualifies them.
  always_ff @(posedge clk_i) begin
    if (fill_c) begin
      data_q[idx_c] <= mem_data_i;
      tag_q[idx_c]  <= tag_c;
    end else if (wr_hit_c) begin
      data_q[idx_c][word_base_c +: 32] <= cpu_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        post_refill_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // The IDLE cycle right after REFILL completes a miss and is not counted as a hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      post_refill_q <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      post_refill_q <= (state_q == S_REFILL);
      if ((state_q == S_IDLE) && hit_c && !post_refill_q) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if ((state_q == S_IDLE) && miss_c) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios then random traffic against a
// line-level cache/memory reference model; the bench itself plays the off-chip memory.
module tb_dcache_ctrl;

  localparam int unsigned NUM_LINES = 16;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-line state keyed by full line address, plus backing memory.
  bit           m_valid [NUM_LINES];
  bit           m_dirty [NUM_LINES];
  logic [31:0]  m_la    [NUM_LINES];
  logic [255:0] m_line  [NUM_LINES];
  logic [255:0] mem [logic [31:0]];
  int           m_hits   = 0;
  int           m_misses = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] la);
    if (!mem.exists(la)) mem[la] = rand_line();
    return mem[la];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  // One memory transaction: request visible, acked after 'delay' waiting cycles.
  task automatic serve(input bit exp_we, input logic [31:0] exp_addr, input logic [255:0] exp_wdata,
                       input int delay, inout int stalls);
    for (int k = 0; k <= delay; k++) begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (k == delay) begin
        mem_ack_i  = 1'b1;
        mem_data_i = exp_we ? rand_line() : get_line(exp_addr);
      end
      #1;
      check("mem_req_held", 256'(mem_req_o), 256'(1));
      check("stall_in_xfer", 256'(cpu_stall_o), 256'(1));
      if (k == 0) begin
        check("mem_we", 256'(mem_we_o), 256'(exp_we));
        check("mem_addr", 256'(mem_addr_o), 256'(exp_addr));
        if (exp_we) check("wb_data", mem_data_o, exp_wdata);
      end
      stalls++;
    end
  endtask

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd, input int delay);
    int          idx;
    int          w;
    logic [31:0] la;
    bit          hit;
    bit          dirty_victim;
    int          stalls;
    idx = int'((addr >> 5) % NUM_LINES);
    w   = int'(addr[4:2]);
    la  = addr & 32'hFFFF_FFE0;
    hit = m_valid[idx] && (m_la[idx] == la);
    @(negedge clk_i);
    mem_ack_i  = 1'b0;
    cpu_req_i  = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_data_i = wd;
    #1;
    check("idle_no_memreq", 256'(mem_req_o), 256'(0));
    if (hit) begin
      m_hits++;
      check("hit_stall", 256'(cpu_stall_o), 256'(0));
    end else begin
      m_misses++;
      check("miss_stall", 256'(cpu_stall_o), 256'(1));
      check("miss_rdata", 256'(cpu_data_o), 256'(0));
      dirty_victim = m_valid[idx] && m_dirty[idx];
      stalls = 1;
      if (dirty_victim) begin
        serve(1'b1, m_la[idx], m_line[idx], delay, stalls);
        mem[m_la[idx]] = m_line[idx];
      end
      serve(1'b0, la, '0, delay, stalls);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_la[idx]    = la;
      m_line[idx]  = get_line(la);
      @(negedge clk_i);
      mem_ack_i  = 1'b0;
      mem_data_i = rand_line();
      #1;
      check("refill_req_low", 256'(mem_req_o), 256'(0));
      check("refill_stall", 256'(cpu_stall_o), 256'(1));
      stalls++;
      @(negedge clk_i);
      #1;
      check("complete_stall", 256'(cpu_stall_o), 256'(0));
      check("complete_req_low", 256'(mem_req_o), 256'(0));
      check("stall_cycles", 256'(stalls), 256'(delay + 3 + (dirty_victim ? delay + 1 : 0)));
    end
    if (we) begin
      m_line[idx][w*32 +: 32] = wd;
      m_dirty[idx] = 1'b1;
    end else begin
      check("load_data", 256'(cpu_data_o), 256'(m_line[idx][w*32 +: 32]));
    end
  endtask

  task automatic idle_cycle(input bit stray_ack);
    @(negedge clk_i);
    cpu_req_i  = 1'b0;
    cpu_we_i   = 1'b0;
    mem_ack_i  = stray_ack;
    mem_data_i = rand_line();
    #1;
    check("idle_stall", 256'(cpu_stall_o), 256'(0));
    check("idle_rdata", 256'(cpu_data_o), 256'(0));
    check("idle_memreq", 256'(mem_req_o), 256'(0));
  endtask

  initial begin
    logic [255:0] l40;
    logic [31:0]  a;
    model_reset();

    // Outputs during reset
    @(negedge clk_i);
    #1;
    check("rst_rdata", 256'(cpu_data_o), 256'(0));
    check("rst_stall", 256'(cpu_stall_o), 256'(0));
    check("rst_memreq", 256'(mem_req_o), 256'(0));
    check("rst_memwe", 256'(mem_we_o), 256'(0));
    check("rst_memaddr", 256'(mem_addr_o), 256'(0));
    check("rst_memdata", mem_data_o, 256'(0));
`ifdef DCACHE_STATS_EN
    check("rst_hitcnt", 256'(hit_cnt_o), 256'(0));
    check("rst_misscnt", 256'(miss_cnt_o), 256'(0));
`endif
    @(negedge clk_i);
    rst_i = 1'b1;
    idle_cycle(1'b0);

    // Directed: fill, store hit, load hit, dirty conflict
    l40 = rand_line();
    l40[31:0] = 32'h1234_5678;
    mem[32'h40] = l40;
    access(1'b0, 32'h40, '0, 2);
    check("load40_const", 256'(cpu_data_o), 256'(32'h1234_5678));
    access(1'b1, 32'h44, 32'hDEAD_BEEF, 0);
    access(1'b0, 32'h44, '0, 0);
    check("load44_const", 256'(cpu_data_o), 256'(32'hDEAD_BEEF));
    access(1'b0, 32'h244, '0, 1);
    check("wb_mem_word1", 256'(mem[32'h40][63:32]), 256'(32'hDEAD_BEEF));

    // Ack delay sweep on clean misses, stray acks in idle between them
    access(1'b0, 32'h1000, '0, 0);
    idle_cycle(1'b1);
    access(1'b0, 32'h1020, '0, 1);
    idle_cycle(1'b1);
    access(1'b0, 32'h1060, '0, 10);
    idle_cycle(1'b0);

    // Random traffic over a small address window to get hits, conflicts and write-backs
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle_cycle(1'($urandom_range(0, 1)));
      end else begin
        a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5) |
            (32'($urandom_range(0, 7)) << 2);
        access(1'($urandom_range(0, 1)), a, $urandom(), int'($urandom_range(0, 3)));
      end
    end
    idle_cycle(1'b0);

`ifdef DCACHE_STATS_EN
    check("hit_cnt", 256'(hit_cnt_o), 256'(m_hits));
    check("miss_cnt", 256'(miss_cnt_o), 256'(m_misses));
`endif

    // Reset in the middle of a fetch, then a late ack
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h2080;
    #1;
    check("pre_rst_stall", 256'(cpu_stall_o), 256'(1));
    @(negedge clk_i);
    #1;
    check("pre_rst_fetch", 256'(mem_req_o), 256'(1));
    @(negedge clk_i);
    rst_i     = 1'b0;
    cpu_req_i = 1'b0;
    #1;
    model_reset();
    check("midrst_memreq", 256'(mem_req_o), 256'(0));
    check("midrst_memaddr", 256'(mem_addr_o), 256'(0));
    check("midrst_stall", 256'(cpu_stall_o), 256'(0));
    @(negedge clk_i);
    rst_i      = 1'b1;
    mem_ack_i  = 1'b1;
    mem_data_i = rand_line();
    #1;
    check("late_ack_memreq", 256'(mem_req_o), 256'(0));
    idle_cycle(1'b0);
    access(1'b0, 32'h2080, '0, 2);
    access(1'b0, 32'h40, '0, 1);
    access(1'b0, 32'h40, '0, 0);
    idle_cycle(1'b0);
`ifdef DCACHE_STATS_EN
    check("hit_cnt_post_rst", 256'(hit_cnt_o), 256'(m_hits));
    check("miss_cnt_post_rst", 256'(miss_cnt_o), 256'(m_misses));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
